disp_arbiter: RTL and testbench

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_arbiter_if.sv | 22 ++
 rtl/disp_arbiter.sv | 52 +++++
 tb/tb_disp_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/disp_arbiter_if.sv
// disp_arbiter_if: requester inputs and TM1638-facing outputs of the display arbiter
interface disp_arbiter_if;
  logic        req_a;
  logic [31:0] dig_a;
  logic [7:0]  led_a;
  logic        req_b;
  logic [31:0] dig_b;
  logic [7:0]  led_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [3:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [7:0]  led;
  logic        upd;
  modport master (
    output req_a, dig_a, led_a, req_b, dig_b, led_b,
    input  gnt_a, gnt_b, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, led, upd
  );
  modport slave (
    input  req_a, dig_a, led_a, req_b, dig_b, led_b,
    output gnt_a, gnt_b, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, led, upd
  );
endinterface

// File: rtl/disp_arbiter.sv
// disp_arbiter: two-requester display arbiter; alert B preempts A only after A's dwell expires
module disp_arbiter #(
  parameter int unsigned DWELL     = 1000,
  parameter logic [3:0]  BLANK_DIG = 4'hF
) (
  input logic CLK,
  input logic RST,
  disp_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;
  localparam logic [15:0] DW = 16'(DWELL);
  state_t      st, nxt;
  logic [15:0] cnt;
  logic [31:0] dig, ndig;
  logic [7:0]  led, nled;
  always_comb begin
    nxt  = st == OWN_A ? ((!bus.req_a || (bus.req_b && cnt == DW)) ? GAP : OWN_A)
         : st == OWN_B ? (bus.req_b ? OWN_B : GAP)
         : bus.req_b ? OWN_B : (bus.req_a ? OWN_A : IDLE);
    ndig = nxt == OWN_A ? bus.dig_a : nxt == OWN_B ? bus.dig_b : {8{BLANK_DIG}};
    nled = nxt == OWN_A ? bus.led_a : nxt == OWN_B ? bus.led_b : 8'h00;
  end
  // counter restarts on every ownership entry, so a reset or gap forfeits dwell credit
  always_ff @(posedge CLK) begin
    if (RST) begin
      st        <= IDLE;
      cnt       <= '0;
      dig       <= {8{BLANK_DIG}};
      led       <= 8'h00;
      bus.gnt_a <= 1'b0;
      bus.gnt_b <= 1'b0;
      bus.upd   <= 1'b0;
    end else begin
      st        <= nxt;
      cnt       <= (nxt != st || st == IDLE || st == GAP) ? '0 : cnt + 16'(cnt != DW);
      dig       <= ndig;
      led       <= nled;
      bus.gnt_a <= nxt == OWN_A;
      bus.gnt_b <= nxt == OWN_B;
      bus.upd   <= {ndig, nled} != {dig, led};
    end
  end
  assign bus.seg0 = dig[3:0];
  assign bus.seg1 = dig[7:4];
  assign bus.seg2 = dig[11:8];
  assign bus.seg3 = dig[15:12];
  assign bus.seg4 = dig[19:16];
  assign bus.seg5 = dig[23:20];
  assign bus.seg6 = dig[27:24];
  assign bus.seg7 = dig[31:28];
  assign bus.led  = led;
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed checks of arbitration, dwell preemption, gap, reset and upd (DWELL=4)
module tb_disp_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  disp_arbiter_if bus();
  disp_arbiter #(.DWELL(4), .BLANK_DIG(4'hF)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] segs();
    return {bus.seg7, bus.seg6, bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  endfunction
  task automatic own(input string tag, input logic a, input logic b, input logic [31:0] d, input logic [7:0] l);
    chk({tag, "_gnt_a"}, 32'(bus.gnt_a), 32'(a));
    chk({tag, "_gnt_b"}, 32'(bus.gnt_b), 32'(b));
    chk({tag, "_segs"}, segs(), d);
    chk({tag, "_led"}, 32'(bus.led), 32'(l));
  endtask
  initial begin
    bus.req_a = 0; bus.req_b = 0;
    bus.dig_a = 32'h22119211; bus.led_a = 8'h5A;
    bus.dig_b = 32'hABCDEF01; bus.led_b = 8'hC3;
    tick(); tick();
    rst = 0;
    own("reset", 0, 0, 32'hFFFFFFFF, 8'h00);
    chk("reset_upd", 32'(bus.upd), 0);
    tick();
    chk("idle_upd", 32'(bus.upd), 0);
    bus.req_a = 1;
    tick();
    own("grant_a", 1, 0, 32'h22119211, 8'h5A);
    chk("seg3", 32'(bus.seg3), 32'h9);
    chk("seg7", 32'(bus.seg7), 32'h2);
    chk("grant_a_upd", 32'(bus.upd), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stable_upd", 32'(bus.upd), 0);
    end
    bus.dig_a = 32'h22119219;
    tick();
    chk("digit_change", segs(), 32'h22119219);
    chk("digit_change_upd", 32'(bus.upd), 1);
    tick();
    chk("digit_change_upd_drop", 32'(bus.upd), 0);
    for (int i = 0; i < 3; i++) begin
      bus.led_a = 8'(i + 1);
      tick();
      chk("stream_led", 32'(bus.led), 32'(i + 1));
      chk("stream_upd", 32'(bus.upd), 1);
    end
    bus.led_a = 8'h5A;
    bus.req_a = 0;
    tick();
    own("a_drop_gap", 0, 0, 32'hFFFFFFFF, 8'h00);
    chk("a_drop_gap_upd", 32'(bus.upd), 1);
    tick();
    own("idle_again", 0, 0, 32'hFFFFFFFF, 8'h00);
    chk("idle_again_upd", 32'(bus.upd), 0);
    bus.req_a = 1; bus.req_b = 1;
    tick();
    own("tie_to_b", 0, 1, 32'hABCDEF01, 8'hC3);
    tick();
    own("a_no_preempt_b", 0, 1, 32'hABCDEF01, 8'hC3);
    bus.req_b = 0;
    tick();
    own("b_drop_gap", 0, 0, 32'hFFFFFFFF, 8'h00);
    tick();
    own("gap_to_a", 1, 0, 32'h22119219, 8'h5A);
    tick();
    bus.req_b = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      own("dwell_hold", 1, 0, 32'h22119219, 8'h5A);
    end
    tick();
    own("preempt_gap", 0, 0, 32'hFFFFFFFF, 8'h00);
    tick();
    own("preempt_b", 0, 1, 32'hABCDEF01, 8'hC3);
    rst = 1; bus.req_b = 0;
    tick();
    own("rst_mid_b", 0, 0, 32'hFFFFFFFF, 8'h00);
    chk("rst_mid_b_upd", 32'(bus.upd), 0);
    rst = 0;
    tick();
    own("post_rst_a", 1, 0, 32'h22119219, 8'h5A);
    bus.req_b = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      own("no_dwell_credit", 1, 0, 32'h22119219, 8'h5A);
    end
    tick();
    own("post_rst_preempt_gap", 0, 0, 32'hFFFFFFFF, 8'h00);
    tick();
    own("post_rst_b", 0, 1, 32'hABCDEF01, 8'hC3);
    bus.req_b = 0;
    tick(); tick();
    own("back_to_a", 1, 0, 32'h22119219, 8'h5A);
    bus.req_b = 1;
    tick();
    bus.req_b = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      own("no_pending_b", 1, 0, 32'h22119219, 8'h5A);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
